// File: rtl/alu_ctrl_decoder_pkg.sv
// Shared types and constants for the ALU control decoder and the ALU that
// consumes its control word.
package alu_ctrl_decoder_pkg;

   // ALU operation codes; 4'b1000-4'b1111 are reserved and never produced.
   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_XOR = 4'b0010,
      ALU_ADD = 4'b0011,
      ALU_SUB = 4'b0100,
      ALU_SLL = 4'b0101,
      ALU_SRL = 4'b0110,
      ALU_SRA = 4'b0111
   } alu_op_e;

   // RV32 major opcodes that map onto an ALU operation.
   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   // funct7 values that select the base or alternate (sub/sra) operation.
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // One decoded control word as held in the output and skid registers.
   typedef struct packed {
      alu_op_e op;
      logic    src_imm;
      logic    illegal;
   } ctrl_t;

   localparam ctrl_t CTRL_RESET = '{op: ALU_AND, src_imm: 1'b0, illegal: 1'b0};

   // Occupancy of the two-entry buffer (output register + skid register).
   typedef enum logic [1:0] {
      BUF_EMPTY,
      BUF_ONE,
      BUF_FULL
   } buf_state_e;

   // Picks srl/sra from funct7; legal is cleared for any other funct7.
   function automatic alu_op_e shift_right_op(input logic [6:0] f7, output logic legal);
      legal = 1'b1;
      if (f7 == F7_ALT) begin
         return ALU_SRA;
      end
      if (f7 != F7_BASE) begin
         legal = 1'b0;
      end
      return ALU_SRL;
   endfunction

endpackage

// File: rtl/alu_ctrl_decoder_if.sv
// Handshake and control-word bundle between the instruction source, the
// decoder and the ALU-side consumer.
interface alu_ctrl_decoder_if
   import alu_ctrl_decoder_pkg::*;
#(
   parameter int ERR_CNT_W = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [31:0]          in_instr;
   logic                 out_valid;
   logic                 out_ready;
   alu_op_e              ALU_control;
   logic                 alu_src_imm;
   logic                 illegal;
   logic [ERR_CNT_W-1:0] err_count;

   // Environment side: supplies instructions and accepts control words.
   modport master (
      output in_valid, in_instr, out_ready,
      input  in_ready, out_valid, ALU_control, alu_src_imm, illegal, err_count
   );

   // Decoder side.
   modport slave (
      input  in_valid, in_instr, out_ready,
      output in_ready, out_valid, ALU_control, alu_src_imm, illegal, err_count
   );
endinterface

// File: rtl/alu_ctrl_decoder_lut.sv
// Purely combinational RV32 instruction -> ALU control lookup.
module alu_ctrl_lut
   import alu_ctrl_decoder_pkg::*;
(
   input  logic [31:0] instr,
   output alu_op_e     ALU_control,
   output logic        alu_src_imm,
   output logic        illegal
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       unused_bits;

   assign opcode      = instr[6:0];
   assign funct3      = instr[14:12];
   assign funct7      = instr[31:25];
   assign unused_bits = ^{instr[24:15], instr[11:7]};

   // Decode opcode/funct3/funct7; anything undecodable becomes an illegal add.
   always_comb begin
      logic    legal;
      logic    sr_legal;
      alu_op_e sr_op;
      ALU_control = ALU_ADD;
      alu_src_imm = 1'b0;
      illegal     = 1'b0;
      legal       = 1'b1;
      sr_op       = shift_right_op(funct7, sr_legal);
      case (opcode)
         OPC_R: begin
            alu_src_imm = 1'b0;
            case (funct3)
               3'b000: begin
                  if (funct7 == F7_BASE) begin
                     ALU_control = ALU_ADD;
                  end else if (funct7 == F7_ALT) begin
                     ALU_control = ALU_SUB;
                  end else begin
                     legal = 1'b0;
                  end
               end
               3'b001: ALU_control = ALU_SLL;
               3'b100: ALU_control = ALU_XOR;
               3'b101: begin
                  ALU_control = sr_op;
                  legal       = sr_legal;
               end
               3'b110: ALU_control = ALU_OR;
               3'b111: ALU_control = ALU_AND;
               default: legal = 1'b0;
            endcase
         end
         OPC_I: begin
            alu_src_imm = 1'b1;
            case (funct3)
               3'b000: ALU_control = ALU_ADD;
               3'b001: begin
                  ALU_control = ALU_SLL;
                  legal       = (funct7 == F7_BASE);
               end
               3'b100: ALU_control = ALU_XOR;
               3'b101: begin
                  ALU_control = sr_op;
                  legal       = sr_legal;
               end
               3'b110: ALU_control = ALU_OR;
               3'b111: ALU_control = ALU_AND;
               default: legal = 1'b0;
            endcase
         end
         OPC_LOAD, OPC_STORE: begin
            ALU_control = ALU_ADD;
            alu_src_imm = 1'b1;
         end
         OPC_BRANCH: begin
            ALU_control = ALU_SUB;
            alu_src_imm = 1'b0;
         end
         default: legal = 1'b0;
      endcase
      if (!legal) begin
         ALU_control = ALU_ADD;
         alu_src_imm = 1'b0;
         illegal     = 1'b1;
      end
   end

endmodule

// File: rtl/alu_ctrl_decoder.sv
// Registered ALU control decoder: combinational lookup feeding a two-entry
// (output + skid) buffer, plus a saturating illegal-instruction counter.
module alu_ctrl_decoder
   import alu_ctrl_decoder_pkg::*;
#(
   parameter int ERR_CNT_W = 8
)(
   input logic               clk,
   input logic               rst_n,
   alu_ctrl_decoder_if.slave bus
);

   localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

   alu_op_e              lut_op;
   logic                 lut_src_imm;
   logic                 lut_illegal;
   ctrl_t                lut_word;
   ctrl_t                out_word;
   ctrl_t                skid_word;
   buf_state_e           state;
   buf_state_e           next_state;
   logic                 in_ready_q;
   logic                 in_fire;
   logic                 out_fire;
   logic                 load_out_lut;
   logic                 load_out_skid;
   logic                 load_skid;
   logic [ERR_CNT_W-1:0] err_cnt;

   alu_ctrl_lut u_lut (
      .instr       (bus.in_instr),
      .ALU_control (lut_op),
      .alu_src_imm (lut_src_imm),
      .illegal     (lut_illegal)
   );

   assign lut_word = '{op: lut_op, src_imm: lut_src_imm, illegal: lut_illegal};
   assign in_fire  = bus.in_valid && in_ready_q;
   assign out_fire = (state != BUF_EMPTY) && bus.out_ready;

   // Buffer occupancy transitions and which register loads from where.
   // A full buffer never sees an input handshake because in_ready is low.
   always_comb begin
      next_state    = state;
      load_out_lut  = 1'b0;
      load_out_skid = 1'b0;
      load_skid     = 1'b0;
      case (state)
         BUF_EMPTY: begin
            if (in_fire) begin
               next_state   = BUF_ONE;
               load_out_lut = 1'b1;
            end
         end
         BUF_ONE: begin
            if (in_fire && out_fire) begin
               load_out_lut = 1'b1;
            end else if (in_fire) begin
               next_state = BUF_FULL;
               load_skid  = 1'b1;
            end else if (out_fire) begin
               next_state = BUF_EMPTY;
            end
         end
         BUF_FULL: begin
            if (out_fire) begin
               next_state    = BUF_ONE;
               load_out_skid = 1'b1;
            end
         end
         default: next_state = BUF_EMPTY;
      endcase
   end

   // State register; in_ready is registered so it stays low for the first
   // cycle out of reset and only drops once the skid slot is occupied.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= BUF_EMPTY;
         in_ready_q <= 1'b0;
      end else begin
         state      <= next_state;
         in_ready_q <= (next_state != BUF_FULL);
      end
   end

   // Output and skid data registers; the output word holds while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_word  <= CTRL_RESET;
         skid_word <= CTRL_RESET;
      end else begin
         if (load_out_lut) begin
            out_word <= lut_word;
         end else if (load_out_skid) begin
            out_word <= skid_word;
         end
         if (load_skid) begin
            skid_word <= lut_word;
         end
      end
   end

   // Count accepted illegal words, sticking at the maximum value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= '0;
      end else if (in_fire && lut_illegal && (err_cnt != ERR_MAX)) begin
         err_cnt <= err_cnt + 1'b1;
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = (state != BUF_EMPTY);
   assign bus.ALU_control = out_word.op;
   assign bus.alu_src_imm = out_word.src_imm;
   assign bus.illegal     = out_word.illegal;
   assign bus.err_count   = err_cnt;

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// Self-checking bench for alu_ctrl_decoder: directed scenarios plus random
// traffic, all checked against a queue-based reference of the buffer.
module tb_alu_ctrl_decoder;
   import alu_ctrl_decoder_pkg::*;

   localparam int ERR_W   = 8;
   localparam int ERR_MAX = (1 << ERR_W) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   alu_ctrl_decoder_if #(.ERR_CNT_W(ERR_W)) dec_if ();

   alu_ctrl_decoder #(.ERR_CNT_W(ERR_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (dec_if)
   );

   int         numChecks = 0;
   int         numErrors = 0;
   logic [5:0] expQ[$];
   int         modelErr = 0;
   int         edgesSinceReset = 0;
   bit         monEnable = 1'b0;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      numChecks++;
      if (observed !== expected) begin
         numErrors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Reference decode, returns {illegal, src_imm, op[3:0]}.
   function automatic logic [5:0] refDecode(input logic [31:0] w);
      int   f3Op[8] = '{3, 5, -1, -1, 2, 6, 1, 0};
      int   op;
      bit   imm;
      logic [6:0] opc;
      logic [6:0] f7;
      int   f3;
      opc = w[6:0];
      f7  = w[31:25];
      f3  = int'(w[14:12]);
      op  = -1;
      imm = 1'b0;
      if (opc == 7'h03 || opc == 7'h23) begin
         op  = 3;
         imm = 1'b1;
      end else if (opc == 7'h63) begin
         op = 4;
      end else if (opc == 7'h33 || opc == 7'h13) begin
         imm = (opc == 7'h13);
         op  = f3Op[f3];
         if (f3 == 0 && !imm) begin
            op = (f7 == 7'h00) ? 3 : (f7 == 7'h20) ? 4 : -1;
         end else if (f3 == 1 && imm && f7 != 7'h00) begin
            op = -1;
         end else if (f3 == 5) begin
            op = (f7 == 7'h00) ? 6 : (f7 == 7'h20) ? 7 : -1;
         end
      end
      if (op < 0) begin
         return {1'b1, 1'b0, 4'd3};
      end
      return {1'b0, imm, 4'(op)};
   endfunction

   function automatic logic [31:0] randInstr();
      logic [31:0] w;
      logic [6:0]  opcs[5] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63};
      w = $urandom;
      if ($urandom_range(0, 5) != 0) begin
         w[6:0] = opcs[$urandom_range(0, 4)];
      end
      case ($urandom_range(0, 2))
         0: w[31:25] = 7'h00;
         1: w[31:25] = 7'h20;
         default: ;
      endcase
      return w;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edgesSinceReset <= 0;
      end else if (edgesSinceReset < 2) begin
         edgesSinceReset <= edgesSinceReset + 1;
      end
   end

   // Scoreboard: compare outputs with the reference queue, then account for
   // the handshakes that will complete at the coming rising edge.
   always @(negedge clk) begin
      bit         expInReady;
      bit         inFire;
      bit         outFire;
      logic [5:0] w;
      if (monEnable && rst_n) begin
         expInReady = (edgesSinceReset >= 1) && (expQ.size() < 2);
         checkOutput("err_count", 32'(dec_if.err_count), 32'(modelErr));
         checkOutput("out_valid", 32'(dec_if.out_valid), 32'(expQ.size() != 0));
         checkOutput("in_ready", 32'(dec_if.in_ready), 32'(expInReady));
         if (expQ.size() != 0 && dec_if.out_valid) begin
            w = expQ[0];
            checkOutput("ALU_control", 32'(dec_if.ALU_control), 32'(w[3:0]));
            checkOutput("alu_src_imm", 32'(dec_if.alu_src_imm), 32'(w[4]));
            checkOutput("illegal", 32'(dec_if.illegal), 32'(w[5]));
         end
         inFire  = dec_if.in_valid && expInReady;
         outFire = (expQ.size() != 0) && dec_if.out_ready;
         if (outFire) begin
            void'(expQ.pop_front());
         end
         if (inFire) begin
            w = refDecode(dec_if.in_instr);
            expQ.push_back(w);
            if (w[5] && modelErr < ERR_MAX) begin
               modelErr++;
            end
         end
      end
   end

   task automatic applyStimulus(input bit valid, input logic [31:0] instr, input bit ready);
      @(posedge clk);
      #1;
      dec_if.in_valid  = valid;
      dec_if.in_instr  = instr;
      dec_if.out_ready = ready;
   endtask

   task automatic doReset();
      rst_n            = 1'b0;
      dec_if.in_valid  = 1'b0;
      dec_if.in_instr  = '0;
      dec_if.out_ready = 1'b0;
      expQ.delete();
      modelErr = 0;
      #1;
      checkOutput("rst_out_valid", 32'(dec_if.out_valid), 32'd0);
      checkOutput("rst_in_ready", 32'(dec_if.in_ready), 32'd0);
      checkOutput("rst_ALU_control", 32'(dec_if.ALU_control), 32'd0);
      checkOutput("rst_alu_src_imm", 32'(dec_if.alu_src_imm), 32'd0);
      checkOutput("rst_illegal", 32'(dec_if.illegal), 32'd0);
      checkOutput("rst_err_count", 32'(dec_if.err_count), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      doReset();
      monEnable = 1'b1;

      // sub right after reset
      applyStimulus(1'b1, 32'h40B50533, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      @(negedge clk);
      checkOutput("sub_valid", 32'(dec_if.out_valid), 32'd1);
      checkOutput("sub_op", 32'(dec_if.ALU_control), 32'h4);

      // back-to-back xor, srai, lw
      applyStimulus(1'b1, 32'h00A5C533, 1'b1);
      applyStimulus(1'b1, 32'h4025D513, 1'b1);
      @(negedge clk);
      checkOutput("b2b_xor", 32'(dec_if.ALU_control), 32'h2);
      applyStimulus(1'b1, 32'h00052503, 1'b1);
      @(negedge clk);
      checkOutput("b2b_srai", 32'(dec_if.ALU_control), 32'h7);
      applyStimulus(1'b0, 32'h0, 1'b1);
      @(negedge clk);
      checkOutput("b2b_lw", 32'(dec_if.ALU_control), 32'h3);

      // stall with three words offered: skid fills, third waits
      applyStimulus(1'b0, 32'h0, 1'b1);
      applyStimulus(1'b1, 32'h00B50533, 1'b0);
      applyStimulus(1'b1, 32'h00B56533, 1'b0);
      applyStimulus(1'b1, 32'h00B57533, 1'b0);
      @(negedge clk);
      checkOutput("stall_in_ready", 32'(dec_if.in_ready), 32'd0);
      applyStimulus(1'b1, 32'h00B57533, 1'b0);
      applyStimulus(1'b1, 32'h00B57533, 1'b1);
      applyStimulus(1'b1, 32'h00B57533, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      repeat (3) applyStimulus(1'b0, 32'h0, 1'b1);

      // slt is illegal, then saturate the counter
      applyStimulus(1'b1, 32'h00B52533, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      @(negedge clk);
      checkOutput("slt_illegal", 32'(dec_if.illegal), 32'd1);
      checkOutput("slt_op", 32'(dec_if.ALU_control), 32'h3);
      checkOutput("slt_err_count", 32'(dec_if.err_count), 32'd1);
      repeat (300) applyStimulus(1'b1, 32'h0, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      @(negedge clk);
      checkOutput("err_saturated", 32'(dec_if.err_count), 32'd255);

      // reset with both buffer entries occupied
      applyStimulus(1'b1, 32'h00B50533, 1'b0);
      applyStimulus(1'b1, 32'h40B50533, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b0);
      @(negedge clk);
      checkOutput("full_before_rst", 32'(dec_if.in_ready), 32'd0);
      doReset();
      repeat (4) applyStimulus(1'b0, 32'h0, 1'b1);

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         applyStimulus($urandom_range(0, 3) != 0, randInstr(), $urandom_range(0, 3) != 0);
      end
      repeat (4) applyStimulus(1'b0, 32'h0, 1'b1);
      @(negedge clk);
      checkOutput("drained", 32'(dec_if.out_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", numChecks, numErrors);
      $finish;
   end

endmodule
